// File: rtl/dart_launcher.sv
// Dart producer: spawns a dart at the tower, steps it each frame_tick, retires it on hit or off-screen, then cools down.
// Optional build macro DART_LAUNCHER_AUTOFIRE_EN makes the tower fire whenever it is able, ignoring fire.
module dart_launcher #(
  parameter int SPEED    = 4,
  parameter int COOLDOWN = 30,
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480
) (
  input  logic        Clk,
  input  logic        reset,
  input  logic        frame_tick,
  input  logic        fire,
  input  logic [19:0] tower_loc,
  input  logic [1:0]  dir,
  input  logic        dart_hit,
  output logic [19:0] dartfile,
  output logic        ready,
  output logic [7:0]  shots
);

  localparam int CW = (COOLDOWN < 2) ? 1 : $clog2(COOLDOWN + 1);
  localparam logic [CW-1:0] COOL_LOAD = CW'(COOLDOWN);
  localparam logic [10:0]   STEP      = 11'(SPEED);
  localparam logic [10:0]   X_LIMIT   = 11'(SCREEN_W);
  localparam logic [10:0]   Y_LIMIT   = 11'(SCREEN_H);

  typedef enum logic [1:0] {IDLE, FLIGHT, RETIRE, COOL} state_t;

  state_t        state, state_n;
  logic [19:0]   dart_n;
  logic [7:0]    shots_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [1:0]    dir_q, dir_n;
  logic          launch_req, launch_ok, out_of_bounds;
  logic [10:0]   x_ext, y_ext, next_coord;

`ifdef DART_LAUNCHER_AUTOFIRE_EN
  assign launch_req = 1'b1;
`else
  assign launch_req = fire;
`endif

  assign launch_ok = launch_req && !dart_hit && (tower_loc != 20'd0);
  assign x_ext     = {1'b0, dartfile[19:10]};
  assign y_ext     = {1'b0, dartfile[9:0]};
  assign ready     = (state == IDLE);

  // Candidate coordinate along the latched direction; a -x/-y step is out once the coordinate would reach 0.
  always_comb begin
    next_coord    = x_ext;
    out_of_bounds = 1'b0;
    case (dir_q)
      2'd0: begin
        next_coord    = x_ext + STEP;
        out_of_bounds = (next_coord >= X_LIMIT);
      end
      2'd1: begin
        next_coord    = x_ext - STEP;
        out_of_bounds = (x_ext <= STEP);
      end
      2'd2: begin
        next_coord    = y_ext + STEP;
        out_of_bounds = (next_coord >= Y_LIMIT);
      end
      default: begin
        next_coord    = y_ext - STEP;
        out_of_bounds = (y_ext <= STEP);
      end
    endcase
  end

  always_comb begin
    state_n = state;
    dart_n  = dartfile;
    shots_n = shots;
    cnt_n   = cnt;
    dir_n   = dir_q;
    case (state)
      IDLE: begin
        dart_n = 20'd0;
        if (launch_ok) begin
          dart_n  = tower_loc;
          dir_n   = dir;
          shots_n = shots + 8'd1;
          state_n = FLIGHT;
        end
      end
      FLIGHT: begin
        if (dart_hit) begin
          dart_n  = 20'd0;
          state_n = RETIRE;
        end else if (frame_tick) begin
          if (out_of_bounds) begin
            dart_n  = 20'd0;
            cnt_n   = COOL_LOAD;
            state_n = COOL;
          end else if (dir_q[1]) begin
            dart_n[9:0] = next_coord[9:0];
          end else begin
            dart_n[19:10] = next_coord[9:0];
          end
        end
      end
      // Hold off until the pop clears so a relaunch cannot land inside it.
      RETIRE: begin
        dart_n = 20'd0;
        if (!dart_hit) begin
          cnt_n   = COOL_LOAD;
          state_n = COOL;
        end
      end
      COOL: begin
        dart_n = 20'd0;
        if (cnt == '0) begin
          state_n = IDLE;
        end else if (frame_tick) begin
          cnt_n = cnt - 1'b1;
        end
      end
      default: begin
        dart_n  = 20'd0;
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      dartfile <= 20'd0;
      shots    <= 8'd0;
      cnt      <= '0;
      dir_q    <= 2'd0;
    end else begin
      state    <= state_n;
      dartfile <= dart_n;
      shots    <= shots_n;
      cnt      <= cnt_n;
      dir_q    <= dir_n;
    end
  end

endmodule

// File: tb/tb_dart_launcher.sv
// Bench for dart_launcher: directed scenarios followed by random traffic, all checked against a
// phase-level reference model of the dart's life (idle, flying, popping, cooling).
module tb_dart_launcher;

  localparam int SPEED    = 4;
  localparam int COOLDOWN = 30;
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  localparam int P_IDLE = 0;
  localparam int P_FLY  = 1;
  localparam int P_POP  = 2;
  localparam int P_COOL = 3;

  logic        Clk = 1'b0;
  logic        reset = 1'b1;
  logic        frame_tick = 1'b0;
  logic        fire = 1'b0;
  logic [19:0] tower_loc = 20'd0;
  logic [1:0]  dir = 2'd0;
  logic        dart_hit = 1'b0;
  logic [19:0] dartfile;
  logic        ready;
  logic [7:0]  shots;

  int cmp_count  = 0;
  int fail_count = 0;

  int m_phase, m_x, m_y, m_dir, m_cool, m_shots;

  always #5 Clk = ~Clk;

  dart_launcher #(
    .SPEED(SPEED), .COOLDOWN(COOLDOWN), .SCREEN_W(SCREEN_W), .SCREEN_H(SCREEN_H)
  ) dut (
    .Clk(Clk), .reset(reset), .frame_tick(frame_tick), .fire(fire), .tower_loc(tower_loc),
    .dir(dir), .dart_hit(dart_hit), .dartfile(dartfile), .ready(ready), .shots(shots)
  );

  function automatic logic [19:0] pack(input int x, input int y);
    logic [9:0] xs, ys;
    xs = x[9:0];
    ys = y[9:0];
    return {xs, ys};
  endfunction

  task automatic check(input string tag, input logic [19:0] obs, input logic [19:0] exp);
    cmp_count++;
    assert (obs === exp) else begin
      fail_count++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = P_IDLE;
    m_x = 0; m_y = 0; m_dir = 0; m_cool = 0; m_shots = 0;
  endtask

  // Advance the model across one clock edge using the inputs currently driven.
  task automatic model_edge();
    int nx, ny;
    bit gone;
    case (m_phase)
      P_IDLE: if (fire && !dart_hit && tower_loc != 20'd0) begin
        m_x = int'(tower_loc[19:10]);
        m_y = int'(tower_loc[9:0]);
        m_dir = int'(dir);
        m_shots = (m_shots + 1) % 256;
        m_phase = P_FLY;
      end
      P_FLY: if (dart_hit) begin
        m_phase = P_POP;
      end else if (frame_tick) begin
        nx = m_x + ((m_dir == 0) ? SPEED : (m_dir == 1) ? -SPEED : 0);
        ny = m_y + ((m_dir == 2) ? SPEED : (m_dir == 3) ? -SPEED : 0);
        gone = (m_dir < 2) ? (nx >= SCREEN_W || nx <= 0) : (ny >= SCREEN_H || ny <= 0);
        if (gone) begin
          m_phase = P_COOL;
          m_cool = COOLDOWN;
        end else begin
          m_x = nx;
          m_y = ny;
        end
      end
      P_POP: if (!dart_hit) begin
        m_phase = P_COOL;
        m_cool = COOLDOWN;
      end
      default: if (m_cool == 0) m_phase = P_IDLE;
               else if (frame_tick) m_cool--;
    endcase
  endtask

  task automatic checkOutput(input string tag);
    check({tag, "_dart"}, dartfile, (m_phase == P_FLY) ? pack(m_x, m_y) : 20'd0);
    check({tag, "_ready"}, {19'd0, ready}, {19'd0, m_phase == P_IDLE});
    check({tag, "_shots"}, {12'd0, shots}, {12'd0, 8'(m_shots)});
  endtask

  task automatic applyStimulus(input logic f, input logic t, input logic h, input string tag);
    fire = f;
    frame_tick = t;
    dart_hit = h;
    model_edge();
    @(posedge Clk);
    #1;
    checkOutput(tag);
  endtask

  task automatic cool_down(input string tag);
    for (int i = 0; i < 3 * COOLDOWN && m_phase != P_IDLE; i++)
      applyStimulus(1'b1, 1'b1, 1'b0, tag);
    check({tag, "_reached_idle"}, {19'd0, ready}, 20'd1);
  endtask

  initial begin
    model_reset();
    #12;
    checkOutput("reset");
    @(posedge Clk);
    #1;
    reset = 1'b0;

    // Launch at (100,200) going +x, then three ticks.
    tower_loc = pack(100, 200);
    dir = 2'd0;
    applyStimulus(1'b1, 1'b0, 1'b0, "launch");
    check("launch_pos", dartfile, pack(100, 200));
    check("launch_shots", {12'd0, shots}, 20'd1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b0, "move");
    check("move_pos", dartfile, pack(112, 200));
    applyStimulus(1'b1, 1'b0, 1'b0, "fire_in_flight");

    // Asynchronous reset between edges must clear outputs before any clock edge.
    #2 reset = 1'b1;
    #1;
    model_reset();
    checkOutput("async_reset");
    @(posedge Clk);
    #1;
    reset = 1'b0;

    // Leftward flight off the screen edge, then a timed cooldown.
    tower_loc = pack(10, 50);
    dir = 2'd1;
    applyStimulus(1'b1, 1'b0, 1'b0, "left_launch");
    applyStimulus(1'b0, 1'b1, 1'b0, "left_6");
    check("left_6_pos", dartfile, pack(6, 50));
    applyStimulus(1'b0, 1'b1, 1'b0, "left_2");
    check("left_2_pos", dartfile, pack(2, 50));
    applyStimulus(1'b0, 1'b1, 1'b0, "left_out");
    check("left_out_dart", dartfile, 20'd0);
    for (int i = 0; i < COOLDOWN; i++) applyStimulus(1'b1, 1'b1, 1'b0, "cool_tick");
    check("cool_still_busy", {19'd0, ready}, 20'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, "cool_done");
    check("cool_ready", {19'd0, ready}, 20'd1);

    // Hit and tick together: hit wins, then the pop is held for 50 cycles.
    tower_loc = pack(300, 120);
    dir = 2'd2;
    applyStimulus(1'b1, 1'b0, 1'b0, "hit_launch");
    applyStimulus(1'b0, 1'b1, 1'b1, "hit_and_tick");
    check("hit_dart", dartfile, 20'd0);
    for (int i = 0; i < 50; i++) applyStimulus(1'b1, 1'b1, 1'b1, "pop_hold");
    applyStimulus(1'b0, 1'b0, 1'b0, "pop_release");
    cool_down("after_pop");

    // Requests that must be ignored in IDLE.
    tower_loc = 20'd0;
    applyStimulus(1'b1, 1'b0, 1'b0, "zero_tower");
    tower_loc = pack(50, 60);
    applyStimulus(1'b1, 1'b0, 1'b1, "fire_while_hit");

    // Walk the shot counter up to 255 and through the wrap.
    tower_loc = pack(200, 200);
    dir = 2'd3;
    while (m_shots != 0 || cmp_count < 200) begin
      applyStimulus(1'b1, 1'b0, 1'b0, "wrap_launch");
      applyStimulus(1'b0, 1'b0, 1'b1, "wrap_hit");
      applyStimulus(1'b0, 1'b0, 1'b0, "wrap_release");
      cool_down("wrap_cool");
      if (cmp_count > 60000) break;
    end
    check("wrap_shots", {12'd0, shots}, 20'd0);

    // Random traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      tower_loc = ($urandom_range(0, 7) == 0) ? 20'd0
                : pack($urandom_range(0, 700), $urandom_range(0, 500));
      dir = 2'($urandom_range(0, 3));
      applyStimulus($urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1,
                    (m_phase == P_POP) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 11) == 0),
                    "random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, fail_count);
    $finish;
  end

endmodule
